// File: rtl/rom_load_sequencer.sv
// Routes HPS ioctl download bytes into CPU/GFX/PROM write ports and owns core reset,
// releasing the core only after a full-length image and a settle period.
module rom_load_sequencer #(
   parameter logic [15:0] CPU_BASE  = 16'h0000,
   parameter logic [15:0] GFX_BASE  = 16'h4000,
   parameter logic [15:0] PROM_BASE = 16'h6000,
   parameter logic [16:0] IMG_LEN   = 17'h06300,
   parameter int unsigned HOLD_CYC  = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        user_reset,
   output logic [15:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_cpu_we,
   output logic        dn_gfx_we,
   output logic        dn_prom_we,
   output logic        core_reset,
   output logic        rom_ok
);

   localparam int unsigned CNT_W  = 17;
   localparam int unsigned HOLD_W = 16;

   typedef enum logic [2:0] {BOOT, LOAD, CHECK, HOLD, RUN} state_t;

   state_t            state_q, state_d;
   logic              dl_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [15:0]       dn_addr_d;
   logic [7:0]        dn_data_d;
   logic              cpu_we_d, gfx_we_d, prom_we_d;
   logic              core_reset_d, rom_ok_d;
   logic              dl_rise, dl_fall, wr_ok;
   logic [15:0]       a16;

   assign a16     = ioctl_addr[15:0];
   assign dl_rise = ioctl_download & ~dl_q;
   assign dl_fall = ~ioctl_download & dl_q;
   assign wr_ok   = (state_q == LOAD) && ioctl_wr && (ioctl_addr[24:16] == 9'd0);

   // Next-state, byte decode and registered-output next values
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      dn_addr_d    = dn_addr;
      dn_data_d    = dn_data;
      cpu_we_d     = 1'b0;
      gfx_we_d     = 1'b0;
      prom_we_d    = 1'b0;
      rom_ok_d     = rom_ok;
      core_reset_d = 1'b1;

      if (wr_ok) begin
         if (a16 < GFX_BASE) begin
            cpu_we_d  = 1'b1;
            dn_addr_d = a16 - CPU_BASE;
         end else if (a16 < PROM_BASE) begin
            gfx_we_d  = 1'b1;
            dn_addr_d = a16 - GFX_BASE;
         end else if ({1'b0, a16} < IMG_LEN) begin
            prom_we_d = 1'b1;
            dn_addr_d = a16 - PROM_BASE;
         end
         if (cpu_we_d || gfx_we_d || prom_we_d) begin
            dn_data_d = ioctl_dout;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         BOOT: ;
         LOAD: if (dl_fall) state_d = CHECK;
         CHECK: begin
            if (cnt_q == IMG_LEN) begin
               state_d  = HOLD;
               hold_d   = '0;
               rom_ok_d = 1'b1;
            end else begin
               state_d  = BOOT;
               rom_ok_d = 1'b0;
            end
         end
         HOLD: begin
            if (hold_q == HOLD_W'(HOLD_CYC - 1)) state_d = RUN;
            else hold_d = hold_q + HOLD_W'(1);
         end
         RUN: ;
         default: state_d = BOOT;
      endcase

      // A new download pre-empts everything and restarts the length count
      if (dl_rise) begin
         state_d  = LOAD;
         cnt_d    = '0;
         rom_ok_d = 1'b0;
      end

      // Registered from next state so RUN's first cycle already follows user_reset
      core_reset_d = (state_d == RUN) ? user_reset : 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q    <= BOOT;
         dl_q       <= ioctl_download;
         cnt_q      <= '0;
         hold_q     <= '0;
         dn_addr    <= '0;
         dn_data    <= '0;
         dn_cpu_we  <= 1'b0;
         dn_gfx_we  <= 1'b0;
         dn_prom_we <= 1'b0;
         core_reset <= 1'b1;
         rom_ok     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dl_q       <= ioctl_download;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         dn_addr    <= dn_addr_d;
         dn_data    <= dn_data_d;
         dn_cpu_we  <= cpu_we_d;
         dn_gfx_we  <= gfx_we_d;
         dn_prom_we <= prom_we_d;
         core_reset <= core_reset_d;
         rom_ok     <= rom_ok_d;
      end
   end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: random byte data and gaps, expected strobes kept in a
// scoreboard queue built from the address map, plus reset/length/hold/user-reset checks.
module tb_rom_load_sequencer;

   localparam int unsigned HOLD_CYC = 16;
   localparam int IMG   = 'h6300;
   localparam int GFX0  = 'h4000;
   localparam int PROM0 = 'h6000;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        user_reset;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_cpu_we, dn_gfx_we, dn_prom_we;
   logic        core_reset, rom_ok;

   rom_load_sequencer dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .user_reset(user_reset), .dn_addr(dn_addr), .dn_data(dn_data),
      .dn_cpu_we(dn_cpu_we), .dn_gfx_we(dn_gfx_we), .dn_prom_we(dn_prom_we),
      .core_reset(core_reset), .rom_ok(rom_ok)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int kind;
      int addr;
      int data;
      int due;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   n_obs[3];
   int   n_exp[3];
   bit   loading = 1'b0;
   int   model_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int n_we();
      return 32'(dn_cpu_we) + 32'(dn_gfx_we) + 32'(dn_prom_we);
   endfunction

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Strobe monitor: every strobe must match the oldest expected byte, on its due cycle
   always @(negedge clk_sys) begin
      int   nw;
      int   k;
      exp_t e;
      nw = n_we();
      if (nw != 0) begin
         chk("we_onehot", nw, 1);
         k = dn_cpu_we ? 0 : (dn_gfx_we ? 1 : 2);
         n_obs[k]++;
         if (sbq.size() == 0) begin
            chk("unexpected_strobe", nw, 0);
         end else begin
            e = sbq.pop_front();
            chk("we_region", k, e.kind);
            chk("dn_addr", dn_addr, e.addr);
            chk("dn_data", dn_data, e.data);
            chk("latency", cyc, e.due);
         end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
         chk("missing_strobe", nw, 1);
         void'(sbq.pop_front());
      end
   end

   // One ioctl_wr byte; the model decides from the address map whether a strobe is owed
   task automatic send(input int addr, input int gap);
      logic [7:0] d;
      exp_t       e;
      d          = 8'($urandom);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(addr);
      ioctl_dout = d;
      if (loading && addr < IMG) begin
         if (addr < GFX0) begin
            e.kind = 0; e.addr = addr;
         end else if (addr < PROM0) begin
            e.kind = 1; e.addr = addr - GFX0;
         end else begin
            e.kind = 2; e.addr = addr - PROM0;
         end
         e.data = d;
         e.due  = cyc + 1;
         sbq.push_back(e);
         n_exp[e.kind]++;
         if (model_cnt < 'h1FFFF) model_cnt++;
      end
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      repeat (gap) @(negedge clk_sys);
   endtask

   task automatic start_dl();
      for (int i = 0; i < 3; i++) begin
         n_obs[i] = 0;
         n_exp[i] = 0;
      end
      model_cnt      = 0;
      ioctl_download = 1'b1;
      loading        = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_cpu"},  n_obs[0], n_exp[0]);
      chk({tag, "_gfx"},  n_obs[1], n_exp[1]);
      chk({tag, "_prom"}, n_obs[2], n_exp[2]);
      chk({tag, "_sbq"},  sbq.size(), 0);
   endtask

   initial begin
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      user_reset     = 1'b0;

      // T1: reset values held on every cycle of reset
      repeat (3) begin
         @(negedge clk_sys);
         chk("rst_core_reset", core_reset, 1);
         chk("rst_rom_ok", rom_ok, 0);
         chk("rst_we", n_we(), 0);
         chk("rst_dn_addr", dn_addr, 0);
         chk("rst_dn_data", dn_data, 0);
      end
      reset_n = 1'b1;
      @(negedge clk_sys);
      chk("boot_core_reset", core_reset, 1);

      // T3: one byte short of a full image
      start_dl();
      for (int a = 0; a < IMG - 1; a++) send(a, 0);
      ioctl_download = 1'b0;
      loading        = 1'b0;
      repeat (2) @(negedge clk_sys);
      for (int i = 0; i < 40; i += 8) begin
         chk("short_rom_ok", rom_ok, 0);
         chk("short_core_reset", core_reset, 1);
         repeat (8) @(negedge clk_sys);
      end
      chk_counts("short");

      // T6: reset_n pulse mid-download aborts; the still-high download is not resumed
      start_dl();
      for (int a = 0; a < 'h1000; a++) send(a, 0);
      reset_n = 1'b0;
      loading = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      chk("abort_core_reset", core_reset, 1);
      chk("abort_rom_ok", rom_ok, 0);
      send('h20, 0);
      send('h4020, 2);
      chk("abort_no_resume_we", n_we(), 0);
      chk("abort_core_reset2", core_reset, 1);
      ioctl_download = 1'b0;
      repeat (3) @(negedge clk_sys);

      // T2/T4: full image, random gaps, forced back-to-back at CPU/GFX seam, dropped bytes
      start_dl();
      for (int a = 0; a < IMG; a++) begin
         send(a, (a == 'h3FFE || a == 'h3FFF) ? 0 : int'($urandom_range(0, 7) == 0));
         if (a == 'h6005) begin
            send('h7000, 0);
            chk("drop_7000_we", n_we(), 0);
            send('h10000, 0);
            chk("drop_10000_we", n_we(), 0);
         end
      end
      chk("model_len", model_cnt, IMG);
      // Count cycles from the first edge that samples download low: CHECK, then HOLD_CYC HOLD cycles
      ioctl_download = 1'b0;
      loading        = 1'b0;
      for (int i = 1; i <= int'(HOLD_CYC) + 2; i++) begin
         @(negedge clk_sys);
         chk($sformatf("hold_core_reset_%0d", i), core_reset, (i <= int'(HOLD_CYC) + 1) ? 1 : 0);
         chk($sformatf("hold_rom_ok_%0d", i), rom_ok, (i >= 2) ? 1 : 0);
      end
      chk_counts("full");
      chk("full_cpu_total", n_obs[0], 'h4000);
      chk("full_gfx_total", n_obs[1], 'h2000);
      chk("full_prom_total", n_obs[2], 'h300);

      // T5: user_reset pulse in RUN reaches core_reset one clock later
      repeat (3) @(negedge clk_sys);
      chk("run_core_reset", core_reset, 0);
      user_reset = 1'b1;
      chk("ur_pre", core_reset, 0);
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk_sys);
         chk($sformatf("ur_core_reset_%0d", i), core_reset, (i <= 5) ? 1 : 0);
         chk($sformatf("ur_rom_ok_%0d", i), rom_ok, 1);
         if (i == 5) user_reset = 1'b0;
      end

      // New download from RUN clears rom_ok and re-asserts core reset
      start_dl();
      chk("redl_rom_ok", rom_ok, 0);
      chk("redl_core_reset", core_reset, 1);
      ioctl_download = 1'b0;
      loading        = 1'b0;
      repeat (4) @(negedge clk_sys);
      chk("empty_rom_ok", rom_ok, 0);
      chk("empty_core_reset", core_reset, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
